fnd_scan_controller: RTL and testbench
======================================

Name: fnd_scan_controller

Overview:
- Parametrised multi-digit 7-segment (FND) scan driver; successor to the single-digit BCD-to-font decoder.
- Time-multiplexes NUM_DIGITS packed 4-bit codes onto one shared segment bus plus per-digit active-low commons.
- Adds hex mode, leading-zero blanking, per-digit decimal points and per-digit blink.
- Sits between the motor/PWM status logic and the board FND pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- SCAN_DIV, 100000, i_clk cycles per digit slot (1 kHz slot rate at 100 MHz); must be >= 2.
- BLINK_TICKS, 500, scan ticks per blink half-period.
- HEX_EN, 1, 1 = codes A-F rendered as letters; 0 = codes 0xA-0xF blank (8'hFF).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_en  in  1  1 = display on; 0 = all digits dark.
- i_digits  in  4*NUM_DIGITS  packed codes; digit k = i_digits[4k+3:4k]; digit 0 = rightmost/LSD.
- i_dp  in  NUM_DIGITS  1 = light decimal point of digit k.
- i_blank_lz  in  1  1 = suppress leading zeros.
- i_blink_mask  in  NUM_DIGITS  1 = digit k blinks.
- o_fndFont  out  8  active-low segments; bit7 = dp, bits6..0 = g..a.
- o_fndCom  out  NUM_DIGITS  active-low digit commons; at most one bit low.
- o_scan_tick  out  1  one-cycle pulse at each digit advance.

Behaviour:
- Reset: prescaler = 0, digit index = 0, blink counter = 0, blink phase = 0, o_fndCom = all 1s, o_fndFont = 8'hFF, o_scan_tick = 0.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. When count == SCAN_DIV-1:
  - o_scan_tick pulses high for that one cycle (registered).
  - Index advances by one, wrapping NUM_DIGITS-1 -> 0.
- Blink: on each scan tick the blink counter increments. When it reaches BLINK_TICKS-1 it clears and the phase toggles.
- Font, with dp bit set to 1 (dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - HEX_EN=1: A=88, b=83, C=C6, d=A1, E=86, F=8E. HEX_EN=0: codes 0xA-0xF give FF.
  - Bit7 is then cleared when i_dp[k] = 1.
- Leading-zero blank: applies when i_blank_lz = 1 and k >= 1. Digit k is blanked (segments 0x7F-equivalent off) if codes k..NUM_DIGITS-1 are all 0. Digit 0 is never blanked. The dp still follows i_dp on a blanked digit.
- Blink: when phase = 1 and i_blink_mask[k] = 1, o_fndFont = 8'hFF (dp off too). The common is still driven low.
- Output register: o_fndFont and o_fndCom are both registered from the current index and the current inputs every cycle.
  - Both update in the same cycle, so there is no cross-digit ghosting.
  - Latency is 1 cycle from an index or input change to the pins.
- i_en = 0: on the next cycle o_fndCom = all 1s and o_fndFont = 8'hFF. The prescaler, index and blink logic keep running. On re-enable, outputs resume at the current index after 1 cycle.
- Inputs are sampled live each cycle; no latching per scan frame.
- Reset mid-scan: all state returns to reset values on the next edge; the tick is suppressed that cycle.
- NUM_DIGITS = 1: index stays 0 and o_fndCom = 1'b0 when enabled.

Test Plan:
- Reset/scan, NUM_DIGITS=4, SCAN_DIV=4, i_en=1, i_digits=16'h1234 -> o_fndCom cycles E,D,B,7 (digit0 first), each held 4 cycles. Fonts per slot: 99, B0, A4, F9. o_scan_tick pulses every 4th cycle.
- LZ blanking, i_digits=16'h0050, i_blank_lz=1 -> digit3 = FF, digit2 = FF, digit1 = 92, digit0 = C0. With i_digits=16'h0000: digits 3..1 = FF, digit0 = C0. With i_blank_lz=0: all four digits = C0.
- Hex/dp, HEX_EN=1, i_digits=16'hABCF, i_dp=4'b0010 -> fonts 8E, 46 (C with dp), 83, 88. With HEX_EN=0 the same input gives all FF except digit1 = 7F.
- Blink, BLINK_TICKS=2, i_blink_mask=4'b0001 -> digit0 font alternates 90/FF every 2 scan ticks for input 9. Other digits stay unaffected.
- Enable/reset, deassert i_en mid-slot -> next cycle o_fndCom=F, font=FF while o_scan_tick keeps pulsing. Assert i_reset mid-slot -> next cycle index=0, prescaler=0, outputs at reset values. After release, the first tick occurs SCAN_DIV cycles later.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// Multi-digit 7-segment scan driver: time-multiplexes packed 4-bit codes onto one
// shared active-low segment bus with per-digit active-low commons.
module fnd_scan_controller #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_TICKS = 500,
  parameter int HEX_EN      = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_en,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_blank_lz,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  output logic [7:0]              o_fndFont,
  output logic [NUM_DIGITS-1:0]   o_fndCom,
  output logic                    o_scan_tick
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_PENULT = PRE_W'(SCAN_DIV - 2);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_TICKS - 1);

  logic [PRE_W-1:0]      prescaler;
  logic [IDX_W-1:0]      digit_idx;
  logic [BLK_W-1:0]      blink_cnt;
  logic                  blink_phase;
  logic                  slot_end;

  logic [3:0]            codes [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  zero_run;

  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  cur_lz;
  logic [7:0]            font_next;
  logic [NUM_DIGITS-1:0] com_next;

  // Active-low font with dp off; letters only exist when hex mode is enabled.
  function automatic logic [7:0] decode_font(input logic [3:0] code);
    logic [7:0] f;
    case (code)
      4'h0:    f = 8'hC0;
      4'h1:    f = 8'hF9;
      4'h2:    f = 8'hA4;
      4'h3:    f = 8'hB0;
      4'h4:    f = 8'h99;
      4'h5:    f = 8'h92;
      4'h6:    f = 8'h82;
      4'h7:    f = 8'hF8;
      4'h8:    f = 8'h80;
      4'h9:    f = 8'h90;
      4'hA:    f = 8'h88;
      4'hB:    f = 8'h83;
      4'hC:    f = 8'hC6;
      4'hD:    f = 8'hA1;
      4'hE:    f = 8'h86;
      default: f = 8'h8E;
    endcase
    if ((HEX_EN == 0) && (code > 4'h9)) begin
      f = 8'hFF;
    end
    return f;
  endfunction

  assign slot_end = (prescaler == PRE_LAST);

  // The tick register is loaded one cycle early so it is high while the prescaler
  // sits on its last count, i.e. in the same cycle the index advance is decided.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prescaler   <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      o_scan_tick <= 1'b0;
    end else begin
      o_scan_tick <= (prescaler == PRE_PENULT);
      if (slot_end) begin
        prescaler <= '0;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_codes
    assign codes[g] = i_digits[4*g +: 4];
  end

  // upper_zero[k] is set when digit k and every more-significant digit are zero.
  always_comb begin
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run      = zero_run & (codes[k] == 4'd0);
      upper_zero[k] = zero_run;
    end
  end

  always_comb begin
    cur_code  = 4'd0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_code  = codes[k];
        cur_dp    = i_dp[k];
        cur_blink = i_blink_mask[k];
        cur_lz    = (k != 0) && upper_zero[k];
      end
    end
  end

  // Blanking keeps the dp under i_dp control; blink then overrides everything.
  always_comb begin
    font_next = decode_font(cur_code);
    com_next  = '1;
    if (i_blank_lz && cur_lz) begin
      font_next[6:0] = 7'h7F;
    end
    if (cur_dp) begin
      font_next[7] = 1'b0;
    end
    if (blink_phase && cur_blink) begin
      font_next = 8'hFF;
    end
    if (i_en) begin
      com_next = ~(NUM_DIGITS'(1) << digit_idx);
    end else begin
      font_next = 8'hFF;
    end
  end

  // Segments and commons share one register stage so they switch together.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_fndFont <= 8'hFF;
      o_fndCom  <= '1;
    end else begin
      o_fndFont <= font_next;
      o_fndCom  <= com_next;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller: hex and non-hex instances driven
// with directed and random stimulus, checked against a cycle-count based model.
module tb_fnd_scan_controller;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BT = 2;

  localparam logic [7:0] FONT_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dp;
  logic          blank_lz;
  logic [ND-1:0] blink_mask;

  logic [7:0]    font_hex, font_nohex;
  logic [ND-1:0] com_hex, com_nohex;
  logic          tick_hex, tick_nohex;

  logic [7:0]    exp_font_hex, exp_font_nohex;
  logic [ND-1:0] exp_com;
  logic          exp_tick;

  int tests = 0;
  int failures = 0;
  int n = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_TICKS(BT), .HEX_EN(1)
  ) dut_hex (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_digits(digits), .i_dp(dp),
    .i_blank_lz(blank_lz), .i_blink_mask(blink_mask),
    .o_fndFont(font_hex), .o_fndCom(com_hex), .o_scan_tick(tick_hex)
  );

  fnd_scan_controller #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_TICKS(BT), .HEX_EN(0)
  ) dut_nohex (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_digits(digits), .i_dp(dp),
    .i_blank_lz(blank_lz), .i_blink_mask(blink_mask),
    .o_fndFont(font_nohex), .o_fndCom(com_nohex), .o_scan_tick(tick_nohex)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, want);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [4*ND-1:0] d,
                               input logic [ND-1:0] p, input logic lz, input logic [ND-1:0] bm);
    reset      = r;
    en         = e;
    digits     = d;
    dp         = p;
    blank_lz   = lz;
    blink_mask = bm;
  endtask

  // Font the pins should show for digit idx given the live inputs and blink phase.
  function automatic logic [7:0] modelFont(input int idx, input int phase, input bit hex);
    logic [7:0] f;
    logic [3:0] code;
    bit leading;
    code = digits[4*idx +: 4];
    f = (!hex && code >= 4'd10) ? 8'hFF : FONT_TABLE[code];
    leading = blank_lz && (idx > 0);
    for (int j = idx; j < ND; j++) begin
      if (digits[4*j +: 4] != 4'd0) leading = 1'b0;
    end
    if (leading) f = 8'hFF;
    if (dp[idx]) f[7] = 1'b0;
    if (phase != 0 && blink_mask[idx]) f = 8'hFF;
    return f;
  endfunction

  // n = cycles since reset release; slot, index and blink phase follow from it directly.
  task automatic stepCycle();
    int idx;
    int phase;
    @(posedge clk);
    if (reset) begin
      n = 0;
      exp_com        = '1;
      exp_font_hex   = 8'hFF;
      exp_font_nohex = 8'hFF;
    end else begin
      idx   = (n / SD) % ND;
      phase = ((n / SD) / BT) % 2;
      for (int k = 0; k < ND; k++) exp_com[k] = !(en && k == idx);
      exp_font_hex   = en ? modelFont(idx, phase, 1'b1) : 8'hFF;
      exp_font_nohex = en ? modelFont(idx, phase, 1'b0) : 8'hFF;
      n++;
    end
    exp_tick = (n % SD == SD - 1);
    @(negedge clk);
    checkOutput("com_hex", com_hex, exp_com);
    checkOutput("font_hex", font_hex, exp_font_hex);
    checkOutput("tick_hex", tick_hex, exp_tick);
    checkOutput("com_nohex", com_nohex, exp_com);
    checkOutput("font_nohex", font_nohex, exp_font_nohex);
    checkOutput("tick_nohex", tick_nohex, exp_tick);
  endtask

  task automatic runCycles(input int cnt);
    for (int i = 0; i < cnt; i++) stepCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4*ND-1:0] rd;
    logic [3:0] nib;

    applyStimulus(1'b1, 1'b1, 16'h1234, 4'b0000, 1'b0, 4'b0000);
    runCycles(3);

    applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0, 4'b0000);
    runCycles(20);

    applyStimulus(1'b0, 1'b1, 16'h0050, 4'b0000, 1'b1, 4'b0000);
    runCycles(16);
    applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1, 4'b0000);
    runCycles(16);
    applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b0, 4'b0000);
    runCycles(16);
    applyStimulus(1'b0, 1'b1, 16'h0000, 4'b1010, 1'b1, 4'b0000);
    runCycles(16);

    applyStimulus(1'b0, 1'b1, 16'hABCF, 4'b0010, 1'b0, 4'b0000);
    runCycles(16);

    applyStimulus(1'b0, 1'b1, 16'h7779, 4'b0000, 1'b0, 4'b0001);
    runCycles(40);

    runCycles(2);
    applyStimulus(1'b0, 1'b0, 16'h7779, 4'b0000, 1'b0, 4'b0001);
    runCycles(10);
    applyStimulus(1'b0, 1'b1, 16'h7779, 4'b0000, 1'b0, 4'b0001);
    runCycles(10);

    runCycles(2);
    applyStimulus(1'b1, 1'b1, 16'h4321, 4'b0000, 1'b0, 4'b0000);
    runCycles(1);
    applyStimulus(1'b0, 1'b1, 16'h4321, 4'b0000, 1'b0, 4'b0000);
    runCycles(10);

    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < ND; k++) begin
        nib = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0) nib = 4'd0;
        rd[4*k +: 4] = nib;
      end
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, rd,
                    ND'($urandom), $urandom_range(0, 1) == 1, ND'($urandom));
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
